button_debounce_bank: RTL and testbench
=======================================

Name: button_debounce_bank

Overview:
Parametrised input conditioner for the board's push buttons and switches. It is the next generation of the single push/sw sampling used at the CPU top. Each of CHANNELS raw inputs is synchronised and debounced, then presented as a clean level, one-cycle rise/fall pulses, an optional toggle-latched level, and a long-press flag. It sits between the board pins and the CPU top, which uses these outputs for reset, single-step clocking and mode select.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
CNT_W, 16, width of the per-channel debounce counter
DEBOUNCE_CYCLES, 50000, consecutive cycles a new level must persist before acceptance (1 .. 2^CNT_W-1)
LONG_W, 24, width of the per-channel long-press counter
LONG_CYCLES, 5000000, cycles a debounced high must last before btn_held asserts (1 .. 2^LONG_W-1)
TOGGLE_MASK, {CHANNELS{1'b0}}, bit i=1 puts channel i in toggle mode

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
btn_in  input  CHANNELS  raw asynchronous inputs, active-high
btn_level  output  CHANNELS  debounced level; toggle-latched level for TOGGLE_MASK channels
btn_rise  output  CHANNELS  one-cycle pulse on debounced 0->1
btn_fall  output  CHANNELS  one-cycle pulse on debounced 1->0
btn_held  output  CHANNELS  debounced high for >= LONG_CYCLES cycles
any_rise  output  1  OR of btn_rise

Behaviour:
- Reset (rst_n=0, asynchronous): sync flops, stable, counters, toggle latches and all outputs are 0. Outputs are registered, so there are no glitches after reset release.
- Synchroniser: two-flop chain per channel, s1<=btn_in, s2<=s1. Only s2 feeds the debouncer.
- Debounce, per channel:
  - s2==stable: cnt<=0.
  - s2!=stable and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s2!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s2, cnt<=0.
  - Any bounce back to the stable value restarts the count from 0.
  - With DEBOUNCE_CYCLES=1 a change is accepted on the first differing cycle.
- Latency: a clean raw edge reaches stable 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- btn_rise[i] / btn_fall[i]: registered and asserted in exactly the cycle in which stable[i] changes 0->1 / 1->0. Width is one cycle. They never coincide on the same channel.
- Level output:
  - TOGGLE_MASK[i]=0: btn_level[i]=stable[i].
  - TOGGLE_MASK[i]=1: tog[i] inverts on every rise and btn_level[i]=tog[i]. Falls do not affect tog. The inversion is visible in the same cycle btn_rise pulses.
- Long press:
  - lcnt[i] increments while stable[i]=1 and saturates at LONG_CYCLES.
  - btn_held[i]=1 when lcnt reaches LONG_CYCLES, i.e. LONG_CYCLES cycles after the rise.
  - On stable 1->0, lcnt<=0 and btn_held<=0 in the same cycle btn_fall pulses.
  - There is no counter wrap.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle; any_rise is their OR.
- Reset mid-operation clears everything, including toggle state. If an input is high at reset release, it is debounced normally from stable=0 and produces a rise after 2+DEBOUNCE_CYCLES cycles.
- Counters never exceed their bounds; no arithmetic overflow in any state.

Test Plan:
All scenarios use CHANNELS=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, TOGGLE_MASK=4'b0100.
- Clean press: btn_in[0] 0->1 and held. Required: btn_rise[0] is a single-cycle pulse at the 6th rising edge after the sampling edge, btn_level[0]=1 thereafter, btn_held[0]=1 exactly 10 cycles after the rise.
- Bounce: btn_in[1] toggles 1,0,1,0 on successive cycles, then stays 1. Required: no pulse during the bounces; btn_rise[1] fires 6 edges after the final 0->1; there is exactly one rise.
- Toggle channel: two clean press/release cycles on btn_in[2]. Required: btn_level[2] goes 0->1 at the first rise and 1->0 at the second rise; releases leave it unchanged; btn_rise[2] and btn_fall[2] pulse each time.
- Release: release btn_in[0] after btn_held[0]=1. Required: btn_fall[0] pulses, and btn_held[0] and btn_level[0] drop in the same cycle.
- Simultaneous: btn_in[3:0] 0000->1011 on one edge. Required: btn_rise=1011 in a single cycle, any_rise=1 for that cycle only.
- Reset mid-press: assert rst_n=0 while btn_in[0]=1 and btn_level[2]=1. Required: all outputs are 0 immediately, without waiting for clk. After release, btn_rise[0] fires 6 edges later and btn_level[2] stays 0.

Source files
------------

// File: rtl/button_debounce_bank_if.sv
// Pin-side bundle for the button conditioner: raw inputs in, clean levels and event pulses out.
// The board/bench drives through master; the conditioner sits behind slave.
interface button_debounce_bank_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] btn_level;
  logic [CHANNELS-1:0] btn_rise;
  logic [CHANNELS-1:0] btn_fall;
  logic [CHANNELS-1:0] btn_held;
  logic                any_rise;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_rise,
    input  btn_fall,
    input  btn_held,
    input  any_rise
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_rise,
    output btn_fall,
    output btn_held,
    output any_rise
  );
endinterface

// File: rtl/button_debounce_bank.sv
// Per-channel synchroniser, debouncer, edge pulses, optional toggle latch and long-press flag.
// All outputs come straight from flops so nothing glitches around reset release.
module button_debounce_bank #(
  parameter int unsigned         CHANNELS        = 4,
  parameter int unsigned         CNT_W           = 16,
  parameter int unsigned         DEBOUNCE_CYCLES = 50000,
  parameter int unsigned         LONG_W          = 24,
  parameter int unsigned         LONG_CYCLES     = 5000000,
  parameter logic [CHANNELS-1:0] TOGGLE_MASK     = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_debounce_bank_if.slave  bus
);

  // Terminal count values; a differing sample at DB_LAST is the one that gets accepted.
  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

  logic [CHANNELS-1:0] sync_q1;
  logic [CHANNELS-1:0] sync_q2;

  logic [CHANNELS-1:0] stable_q;
  logic [CHANNELS-1:0] stable_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  logic [LONG_W-1:0]   lcnt_q [CHANNELS];
  logic [LONG_W-1:0]   lcnt_d [CHANNELS];

  logic [CHANNELS-1:0] tog_q;
  logic [CHANNELS-1:0] tog_d;

  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] fall_d;
  logic [CHANNELS-1:0] held_q;
  logic [CHANNELS-1:0] held_d;
  logic                any_q;
  logic                any_d;

  // Two-flop synchroniser; only sync_q2 is allowed into the debouncer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: count consecutive disagreeing samples, any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i] = '0;
      if (sync_q2[i] != stable_q[i]) begin
        if (cnt_q[i] >= DB_LAST) begin
          stable_d[i] = sync_q2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge pulses and toggle latch are derived from the stable transition of this cycle.
  always_comb begin
    rise_d  = stable_d & ~stable_q;
    fall_d  = ~stable_d & stable_q;
    tog_d   = tog_q ^ (rise_d & TOGGLE_MASK);
    level_d = (stable_d & ~TOGGLE_MASK) | (tog_d & TOGGLE_MASK);
    any_d   = |rise_d;
  end

  // Long press: age of the current high level, saturating, cleared together with the fall.
  always_comb begin
    held_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      lcnt_d[i] = lcnt_q[i];
      if (!stable_q[i] || fall_d[i]) begin
        lcnt_d[i] = '0;
      end else if (lcnt_q[i] < LONG_MAX) begin
        lcnt_d[i] = lcnt_q[i] + LONG_W'(1);
      end
      held_d[i] = (lcnt_d[i] == LONG_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      tog_q    <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      held_q   <= '0;
      any_q    <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i]  <= '0;
        lcnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      tog_q    <= tog_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      held_q   <= held_d;
      any_q    <= any_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i]  <= cnt_d[i];
        lcnt_q[i] <= lcnt_d[i];
      end
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_rise  = rise_q;
  assign bus.btn_fall  = fall_q;
  assign bus.btn_held  = held_q;
  assign bus.any_rise  = any_q;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed and randomized checks of button_debounce_bank against a run-length reference model.
module tb_button_debounce_bank;

  localparam int unsigned CH  = 4;
  localparam int          DB  = 4;
  localparam int          LNG = 10;
  localparam logic [3:0]  TM  = 4'b0100;

  logic clk = 1'b0;
  logic rst_n;

  button_debounce_bank_if #(.CHANNELS(CH)) bus ();

  button_debounce_bank #(
    .CHANNELS(CH),
    .CNT_W(16),
    .DEBOUNCE_CYCLES(DB),
    .LONG_W(24),
    .LONG_CYCLES(LNG),
    .TOGGLE_MASK(TM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rise1_cnt = 0;
  int fall2_cnt = 0;

  // Reference model: pin history, run length of disagreement, age of high level, rise parity.
  logic [3:0] m_s1, m_s2, m_stable, m_tog;
  logic [3:0] e_rise, e_fall, e_held, e_level;
  int         run [4];
  int         age [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_tog = '0;
    e_rise = '0; e_fall = '0; e_held = '0; e_level = '0;
    for (int i = 0; i < 4; i++) begin
      run[i] = 0;
      age[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [3:0] old;
    old = m_stable;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_stable[i]) begin
        run[i] = run[i] + 1;
        if (run[i] >= DB) begin
          m_stable[i] = m_s2[i];
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = bus.btn_in;
    e_rise = m_stable & ~old;
    e_fall = ~m_stable & old;
    m_tog  = m_tog ^ (e_rise & TM);
    for (int i = 0; i < 4; i++) begin
      if (old[i] && m_stable[i]) age[i] = (age[i] + 1 > LNG) ? LNG : age[i] + 1;
      else age[i] = 0;
      e_held[i] = (age[i] >= LNG);
    end
    e_level = (m_stable & ~TM) | (m_tog & TM);
  endtask

  task automatic compare_model();
    check("model_level", 32'(bus.btn_level), 32'(e_level));
    check("model_rise",  32'(bus.btn_rise),  32'(e_rise));
    check("model_fall",  32'(bus.btn_fall),  32'(e_fall));
    check("model_held",  32'(bus.btn_held),  32'(e_held));
    check("model_any",   32'(bus.any_rise),  32'(|e_rise));
    rise1_cnt += int'(bus.btn_rise[1]);
    fall2_cnt += int'(bus.btn_fall[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, 32'(bus.btn_level), 32'd0);
    check({tag, "_rise"},  32'(bus.btn_rise),  32'd0);
    check({tag, "_fall"},  32'(bus.btn_fall),  32'd0);
    check({tag, "_held"},  32'(bus.btn_held),  32'd0);
    check({tag, "_any"},   32'(bus.any_rise),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.btn_in = '0;
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Clean press on channel 0: rise on the 6th edge counting the sampling edge.
    bus.btn_in[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check("press_rise_early", 32'(bus.btn_rise[0]), 32'd0);
      if (k == 6) begin
        check("press_rise", 32'(bus.btn_rise[0]), 32'd1);
        check("press_level", 32'(bus.btn_level[0]), 32'd1);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) check("press_rise_width", 32'(bus.btn_rise[0]), 32'd0);
      if (k == 9) check("held_early", 32'(bus.btn_held[0]), 32'd0);
      if (k == 10) check("held_at_10", 32'(bus.btn_held[0]), 32'd1);
    end

    // Bounce on channel 1 then settle high.
    rise1_cnt = 0;
    bus.btn_in[1] = 1'b1; tick();
    bus.btn_in[1] = 1'b0; tick();
    bus.btn_in[1] = 1'b1; tick();
    bus.btn_in[1] = 1'b0; tick();
    bus.btn_in[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check("bounce_rise_early", 32'(bus.btn_rise[1]), 32'd0);
      if (k == 6) check("bounce_rise", 32'(bus.btn_rise[1]), 32'd1);
    end
    repeat (6) tick();
    check("bounce_one_rise", 32'(rise1_cnt), 32'd1);

    // Release channel 0 while held.
    bus.btn_in[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        check("release_held_before", 32'(bus.btn_held[0]), 32'd1);
        check("release_level_before", 32'(bus.btn_level[0]), 32'd1);
      end
      if (k == 6) begin
        check("release_fall", 32'(bus.btn_fall[0]), 32'd1);
        check("release_held", 32'(bus.btn_held[0]), 32'd0);
        check("release_level", 32'(bus.btn_level[0]), 32'd0);
      end
    end

    // Toggle channel: two press/release cycles.
    fall2_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      bus.btn_in[2] = 1'b1;
      repeat (6) tick();
      check("tog_rise", 32'(bus.btn_rise[2]), 32'd1);
      check("tog_level_press", 32'(bus.btn_level[2]), (p == 0) ? 32'd1 : 32'd0);
      repeat (4) tick();
      bus.btn_in[2] = 1'b0;
      repeat (6) tick();
      check("tog_fall", 32'(bus.btn_fall[2]), 32'd1);
      check("tog_level_release", 32'(bus.btn_level[2]), (p == 0) ? 32'd1 : 32'd0);
      repeat (4) tick();
    end
    check("tog_fall_count", 32'(fall2_cnt), 32'd2);

    // Simultaneous press on channels 0, 1 and 3.
    bus.btn_in = 4'b0000;
    repeat (10) tick();
    bus.btn_in = 4'b1011;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) check("simul_any_early", 32'(bus.any_rise), 32'd0);
      if (k == 6) begin
        check("simul_rise", 32'(bus.btn_rise), 32'hb);
        check("simul_any", 32'(bus.any_rise), 32'd1);
      end
      if (k == 7) check("simul_any_width", 32'(bus.any_rise), 32'd0);
    end

    // Reset mid-press with the toggle latch set.
    bus.btn_in[2] = 1'b1;
    repeat (8) tick();
    check("pre_reset_tog", 32'(bus.btn_level[2]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    bus.btn_in[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check("post_reset_rise_early", 32'(bus.btn_rise[0]), 32'd0);
      if (k == 6) check("post_reset_rise", 32'(bus.btn_rise[0]), 32'd1);
    end
    repeat (6) tick();
    check("post_reset_tog", 32'(bus.btn_level[2]), 32'd0);

    // Randomized segments: bouncy bursts followed by steady stretches.
    for (int seg = 0; seg < 200; seg++) begin
      bus.btn_in = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < int'($urandom_range(1, 6)); b++) begin
          tick();
          bus.btn_in = bus.btn_in ^ 4'($urandom);
        end
      end
      repeat ($urandom_range(1, 20)) tick();
      if (seg == 100) begin
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("rand_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
